// File: rtl/conv_pool_writer_if.sv
// Conv-result stream in, pooled feature-buffer writes and frame status out.
interface conv_pool_writer_if #(
  parameter int FILTERS = 6,
  parameter int DW      = 16,
  parameter int AW      = 8
);
  logic                  in_valid;
  logic [FILTERS*DW-1:0] in_data;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [FILTERS*DW-1:0] wr_data;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid, in_data,
    input  wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/conv_pool_writer.sv
// Streaming 2x2/stride-2 max-pool with optional ReLU; writes one pooled word per
// block in pooled raster order and pulses done on the last write of a frame.
module conv_pool_writer #(
  parameter int O_SIZE  = 28,
  parameter int FILTERS = 6,
  parameter int DW      = 16,
  parameter int RELU    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             start,
  conv_pool_writer_if.slave bus
);
  localparam int P_SIZE = O_SIZE / 2;
  localparam int AW     = (P_SIZE * P_SIZE > 1) ? $clog2(P_SIZE * P_SIZE) : 1;
  localparam int CW     = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
  localparam int PW     = (P_SIZE > 1) ? $clog2(P_SIZE) : 1;
  localparam int LW     = FILTERS * DW;
  localparam logic [CW-1:0] LAST_POS  = CW'(O_SIZE - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(P_SIZE * P_SIZE - 1);

  logic [CW-1:0] col, row;
  logic [LW-1:0] hold;
  logic [LW-1:0] line_buf [P_SIZE];

  logic          wr_en_q, busy_q, done_q;
  logic [AW-1:0] wr_addr_q;
  logic [LW-1:0] wr_data_q;

  logic [CW-1:0] eff_col, eff_row;
  logic [PW-1:0] lb_idx;
  logic [LW-1:0] pair, result;
  logic [DW-1:0] blk;
  logic [AW-1:0] addr_c;

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // A start beat is pixel (0,0) of the new frame, so it sees zeroed counters.
  always_comb begin
    eff_col = start ? '0 : col;
    eff_row = start ? '0 : row;
    lb_idx  = PW'(eff_col >> 1);
    addr_c  = AW'((int'(eff_row) >> 1) * P_SIZE + (int'(eff_col) >> 1));
    pair    = '0;
    result  = '0;
    blk     = '0;
    for (int unsigned k = 0; k < FILTERS; k++) begin
      pair[k*DW +: DW] = smax(hold[k*DW +: DW], bus.in_data[k*DW +: DW]);
      blk = smax(line_buf[lb_idx][k*DW +: DW], pair[k*DW +: DW]);
      if (RELU != 0 && blk[DW-1]) blk = '0;
      result[k*DW +: DW] = blk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < P_SIZE; i++) line_buf[PW'(i)] <= '0;
    end else if (clk_en) begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (start) begin
        col    <= '0;
        row    <= '0;
        busy_q <= 1'b0;
      end
      if (bus.in_valid) begin
        busy_q <= 1'b1;
        if (eff_col == LAST_POS) begin
          col <= '0;
          row <= (eff_row == LAST_POS) ? '0 : eff_row + CW'(1);
        end else begin
          col <= eff_col + CW'(1);
        end
        if (!eff_col[0]) begin
          hold <= bus.in_data;
        end else if (!eff_row[0]) begin
          line_buf[lb_idx] <= pair;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_c;
          wr_data_q <= result;
          if (addr_c == LAST_ADDR) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
